// File: rtl/uart_msg_scheduler.sv
// uart_msg_scheduler
//   Shares one uart_tx byte transmitter between four event sources. Each source
//   owns a fixed ASCII message in ROM. A qualified rising edge on ev[i] latches
//   a request. A round-robin scheduler grants one source at a time and streams
//   its message over the uart_tx start/data/busy handshake.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   ev         : event levels, a rising edge on bit i requests message i
//   ev_en      : per-source enable, a masked edge is not latched
//   tx_busy    : uart_tx busy (high while a byte shifts out)
//   tx_start   : one-cycle start pulse to uart_tx
//   tx_data    : byte for uart_tx, valid in the tx_start cycle
//   active     : high from grant until the last byte completes
//   cur_src    : granted source (holds last value when idle)
//   pending    : latched requests not yet granted
//   msg_done   : one-cycle pulse when the last byte of a message completes
module uart_msg_scheduler #(
  parameter int N_SRC = 4,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] ev,
  input  logic [N_SRC-1:0] ev_en,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             active,
  output logic [1:0]       cur_src,
  output logic [N_SRC-1:0] pending,
  output logic             msg_done
);

  // Message ROM, first character in the most significant byte.
  localparam logic [22*8-1:0] MSG0 = "No hay mas porciones\r\n";
  localparam logic [17*8-1:0] MSG1 = "Porcion servida\r\n";
  localparam logic [13*8-1:0] MSG2 = "Tanque bajo\r\n";
  localparam logic [16*8-1:0] MSG3 = "Puerta abierta\r\n";

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} state_t;

  state_t           state;
  logic [1:0]       rr_last;
  logic [N_SRC-1:0] ev_d;
  logic [IDX_W-1:0] idx;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic             gnt_vld;
  logic [1:0]       gnt_src;
  logic [1:0]       cand;

  function automatic logic [IDX_W-1:0] msg_last(input logic [1:0] s);
    logic [IDX_W-1:0] l;
    case (s)
      2'd0:    l = IDX_W'(21);
      2'd1:    l = IDX_W'(16);
      2'd2:    l = IDX_W'(12);
      default: l = IDX_W'(15);
    endcase
    return l;
  endfunction

  // Byte i of message s: shift the i-th character down to the low byte.
  function automatic logic [7:0] rom_byte(input logic [1:0] s, input logic [IDX_W-1:0] i);
    logic [7:0] b;
    case (s)
      2'd0:    b = 8'(MSG0 >> ((21 - int'(i)) * 8));
      2'd1:    b = 8'(MSG1 >> ((16 - int'(i)) * 8));
      2'd2:    b = 8'(MSG2 >> ((12 - int'(i)) * 8));
      default: b = 8'(MSG3 >> ((15 - int'(i)) * 8));
    endcase
    return b;
  endfunction

  assign rise = ev & ~ev_d & ev_en;

  // Round-robin pick: first pending source after the last one served.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_src = rr_last;
    cand    = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = rr_last + 2'(k);
      if (!gnt_vld && pending[cand]) begin
        gnt_vld = 1'b1;
        gnt_src = cand;
      end
    end
  end

  always_comb begin
    clr = '0;
    if (state == IDLE && gnt_vld) clr[gnt_src] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_last  <= 2'd3;
      ev_d     <= '0;
      idx      <= '0;
      pending  <= '0;
      cur_src  <= '0;
      active   <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      msg_done <= 1'b0;
    end else begin
      ev_d     <= ev;
      tx_start <= 1'b0;
      msg_done <= 1'b0;
      // Set after clear so a new edge on the granted source re-arms it.
      pending  <= (pending & ~clr) | rise;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            cur_src <= gnt_src;
            idx     <= '0;
            active  <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= rom_byte(cur_src, idx);
            state    <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (tx_busy) state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            if (idx == msg_last(cur_src)) begin
              msg_done <= 1'b1;
              active   <= 1'b0;
              rr_last  <= cur_src;
              state    <= IDLE;
            end else begin
              idx   <= idx + 1'b1;
              state <= LOAD;
            end
          end
        end
        default: begin
          active <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_msg_scheduler.sv
module tb_uart_msg_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] ev = '0;
  logic [3:0] ev_en = 4'hF;
  logic       ext_busy = 1'b0;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       active;
  logic [1:0] cur_src;
  logic [3:0] pending;
  logic       msg_done;

  int checks = 0;
  int errors = 0;

  uart_msg_scheduler dut (
    .clk(clk), .rst_n(rst_n), .ev(ev), .ev_en(ev_en), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .active(active), .cur_src(cur_src),
    .pending(pending), .msg_done(msg_done)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: busy rises one clock after start, stays high 10 clocks.
  int bcnt = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) bcnt <= 0;
    else if (tx_start) bcnt <= 10;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  assign tx_busy = (bcnt != 0) | ext_busy;

  string msgs [4] = '{"No hay mas porciones\r\n", "Porcion servida\r\n",
                      "Tanque bajo\r\n", "Puerta abierta\r\n"};

  // ---------------- reference model ----------------
  logic [3:0] m_pend, m_evd;
  logic [1:0] m_rr, m_cur;
  logic       m_act, m_start, m_done;
  logic [7:0] m_data;

  function automatic int pick(input logic [3:0] p, input logic [1:0] rr);
    for (int k = 1; k <= 4; k++)
      if (p[(int'(rr) + k) % 4]) return (int'(rr) + k) % 4;
    return -1;
  endfunction

  // Advance one clock edge; b is tx_busy as seen by that edge, ab flags reset.
  task automatic tick(input logic [3:0] clr, output logic b, output bit ab);
    @(posedge clk or negedge rst_n);
    ab = !rst_n;
    b  = tx_busy;
    if (!ab) begin
      m_start = 1'b0;
      m_done  = 1'b0;
      m_pend  = (m_pend & ~clr) | (ev & ~m_evd & ev_en);
      m_evd   = ev;
    end
  endtask

  initial begin : model_p
    logic b;
    bit   ab;
    int   s;
    forever begin
      m_pend = '0; m_evd = '0; m_rr = 2'd3; m_cur = '0;
      m_act = 1'b0; m_start = 1'b0; m_done = 1'b0; m_data = '0;
      wait (rst_n === 1'b1);
      ab = 1'b0;
      while (!ab) begin
        s = pick(m_pend, m_rr);
        tick((s < 0) ? 4'd0 : 4'(1 << s), b, ab);
        if (ab || s < 0) continue;
        m_cur = 2'(s);
        m_act = 1'b1;
        for (int i = 0; i < msgs[s].len() && !ab; i++) begin
          // each byte: wait for idle line, start, see busy rise, see busy fall
          do tick('0, b, ab); while (!ab && b);
          if (ab) break;
          m_start = 1'b1;
          m_data  = msgs[s][i];
          do tick('0, b, ab); while (!ab && !b);
          if (ab) break;
          do tick('0, b, ab); while (!ab && b);
        end
        if (!ab) begin
          m_done = 1'b1;
          m_act  = 1'b0;
          m_rr   = 2'(s);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic busy_e = 1'b0;
  always @(posedge clk) busy_e <= tx_busy;

  always @(negedge clk) begin
    bit ok;
    checks++;
    if (!rst_n)
      ok = (tx_start === 1'b0) && (tx_data === 8'h00) && (active === 1'b0) &&
           (cur_src === 2'd0) && (pending === 4'h0) && (msg_done === 1'b0);
    else
      ok = (tx_start === m_start) && (!m_start || tx_data === m_data) &&
           (active === m_act) && (cur_src === m_cur) && (pending === m_pend) &&
           (msg_done === m_done);
    if (!ok) begin
      errors++;
      $display("FAIL cycle_compare t=%0t got start=%b data=%h act=%b src=%0d pend=%b done=%b want start=%b data=%h act=%b src=%0d pend=%b done=%b",
               $time, tx_start, tx_data, active, cur_src, pending, msg_done,
               m_start, m_data, m_act, m_cur, m_pend, m_done);
    end
    if (rst_n && tx_start) begin
      checks++;
      if (busy_e !== 1'b0) begin
        errors++;
        $display("FAIL start_while_busy t=%0t busy=%b required 0", $time, busy_e);
      end
    end
  end

  // ---------------- observation for directed tests ----------------
  logic [7:0] bytes[$];
  int         grants[$];
  int         dones = 0;
  logic       act_q = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) act_q = 1'b0;
    else begin
      if (tx_start) bytes.push_back(tx_data);
      if (msg_done) dones++;
      if (active && !act_q) grants.push_back(int'(cur_src));
      act_q = active;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_quiet(input int maxc, input string nm);
    int n = 0;
    int q = 0;
    while (q < 3 && n < maxc) begin
      @(negedge clk);
      n++;
      if (!active && pending == 4'h0 && !tx_busy) q++;
      else q = 0;
    end
    if (q < 3) begin
      checks++;
      errors++;
      $display("FAIL %s timeout after %0d cycles, required idle", nm, n);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int n;
    #1 rst_n = 1'b0;
    cyc(3);
    chk("reset_tx_start", tx_start, 0);
    chk("reset_tx_data", tx_data, 0);
    chk("reset_active", active, 0);
    chk("reset_pending", pending, 0);
    chk("reset_cur_src", cur_src, 0);
    chk("reset_msg_done", msg_done, 0);
    #2 rst_n = 1'b1;
    cyc(3);

    // T1: single message from source 0
    bytes.delete(); grants.delete(); dones = 0;
    ev[0] = 1'b1;
    lat = 0;
    while (!tx_start && lat < 10) begin @(negedge clk); lat++; end
    chk("t1_grant_latency", lat, 3);
    wait_quiet(600, "t1_idle");
    chk("t1_nbytes", bytes.size(), 22);
    chk("t1_byte0", bytes[0], 8'h4E);
    chk("t1_byte1", bytes[1], 8'h6F);
    chk("t1_byte2", bytes[2], 8'h20);
    chk("t1_byte20", bytes[20], 8'h0D);
    chk("t1_byte21", bytes[21], 8'h0A);
    chk("t1_done_count", dones, 1);
    ev = '0; cyc(2);

    // T2: round-robin order
    grants.delete();
    ev[3] = 1'b1; ev[1] = 1'b1;
    wait_quiet(1000, "t2a_idle");
    chk("t2a_ngrants", grants.size(), 2);
    chk("t2a_first", grants[0], 1);
    chk("t2a_second", grants[1], 3);
    ev = '0; cyc(2);
    grants.delete();
    ev[1] = 1'b1; ev[2] = 1'b1;
    wait_quiet(1000, "t2b_idle");
    chk("t2b_first", grants[0], 1);
    chk("t2b_second", grants[1], 2);
    ev = '0; cyc(2);

    // T3: coalesce three pulses, then re-arm during own transmission
    grants.delete(); bytes.delete();
    ev[0] = 1'b1;
    cyc(5);
    repeat (3) begin ev[2] = 1'b1; cyc(2); ev[2] = 1'b0; cyc(2); end
    n = 0;
    while (grants.size() < 2 && n < 600) begin @(negedge clk); n++; end
    cyc(40);
    ev[2] = 1'b1; cyc(2); ev[2] = 1'b0;
    wait_quiet(1000, "t3_idle");
    chk("t3_ngrants", grants.size(), 3);
    chk("t3_g1", grants[1], 2);
    chk("t3_g2", grants[2], 2);
    chk("t3_nbytes", bytes.size(), 22 + 13 + 13);
    ev = '0; cyc(2);

    // T4: masked edge is not latched
    grants.delete(); bytes.delete();
    ev_en = 4'b1110;
    ev[0] = 1'b1;
    cyc(5);
    chk("t4_pending_masked", pending, 0);
    cyc(20);
    chk("t4_no_start", bytes.size(), 0);
    ev[1] = 1'b1;
    wait_quiet(600, "t4_idle");
    chk("t4_grant", grants[0], 1);
    chk("t4_nbytes", bytes.size(), 17);
    ev = '0; cyc(2); ev_en = 4'hF;

    // T5: uart_tx already busy when the request arrives
    bytes.delete();
    ext_busy = 1'b1;
    ev[3] = 1'b1;
    cyc(30);
    chk("t5_no_start", bytes.size(), 0);
    chk("t5_active", active, 1);
    ext_busy = 1'b0;
    wait_quiet(600, "t5_idle");
    chk("t5_nbytes", bytes.size(), 16);
    ev = '0; cyc(2);

    // T6: reset in the middle of message 0
    bytes.delete();
    ev[0] = 1'b1;
    n = 0;
    while (bytes.size() < 5 && n < 400) begin @(negedge clk); n++; end
    chk("t6_reached_byte5", bytes.size(), 5);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_async_tx_start", tx_start, 0);
    chk("t6_async_active", active, 0);
    chk("t6_async_cur_src", cur_src, 0);
    chk("t6_async_tx_data", tx_data, 0);
    ev = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    bytes.delete();
    cyc(50);
    chk("t6_no_tx_after_reset", bytes.size(), 0);
    chk("t6_idle_after_reset", active, 0);
    ev[2] = 1'b1;
    wait_quiet(600, "t6_idle");
    chk("t6_new_edge_nbytes", bytes.size(), 13);
    ev = '0; cyc(2);

    // Random phase: the per-cycle compare checks everything here.
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 15) == 0) ev[b] = ~ev[b];
      if ($urandom_range(0, 199) == 0) ev_en = 4'($urandom);
      ext_busy = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 1499) == 0) begin
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    ev = '0; ev_en = 4'hF; ext_busy = 1'b0;
    wait_quiet(4000, "final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
